// File: rtl/capture_pkg.sv
// Shared definitions for the sample-capture write side and the playback
// address counter. Both ends must agree on the buffer depth (wrap point)
// and the address/data widths.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } capture_state_t;

    localparam int SAMPLE_DEPTH = 10000;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int OVR_W        = 16;

endpackage

// File: rtl/capture_ptr.sv
// Write pointer and fill counter for one capture.
// The pointer stops at DEPTH-1 (no wrap inside a capture), while the fill
// count is allowed to reach DEPTH so it reports the full buffer.
module capture_ptr
    import capture_pkg::*;
#(
    parameter int DEPTH = SAMPLE_DEPTH,
    parameter int PTR_W = ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr,
    output logic [PTR_W-1:0] o_fill,
    output logic             o_last
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_fill;
    logic             w_last;

    assign w_last = (r_ptr == PTR_W'(DEPTH - 1));

    // clear on capture start, advance on each accepted sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr  <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_ptr  <= '0;
            r_fill <= '0;
        end else if (i_inc) begin
            r_fill <= r_fill + PTR_W'(1);
            if (!w_last) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
        end
    end

    assign o_ptr  = r_ptr;
    assign o_fill = r_fill;
    assign o_last = w_last;

endmodule

// File: rtl/capture_writer.sv
// Capture writer: takes samples over valid/ready and writes them into the
// shared sample RAM at addresses 0..DEPTH-1, in playback order.
// Optional feature macro: CAPTURE_OVERRUN_CNT_EN adds o_overrun_cnt, a
// saturating count of samples offered while no capture is running.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; in_ready low, fill holds last result
// CAPTURE | accepting samples, one registered RAM write per accept
// DONE    | one-cycle done pulse (coincides with the final write)
module capture_writer
    import capture_pkg::*;
#(
    parameter int DEPTH = SAMPLE_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_fill
`ifdef CAPTURE_OVERRUN_CNT_EN
    ,
    output logic [OVR_W-1:0]  o_overrun_cnt
`endif
);

    capture_state_t    r_state;
    capture_state_t    w_next;
    logic              w_accept;
    logic              w_clr;
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] w_fill;
    logic              w_last;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    capture_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (ADDR_W)
    ) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_inc  (w_accept),
        .o_ptr  (w_ptr),
        .o_fill (w_fill),
        .o_last (w_last)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state, accept and pointer clear; start outranks stop in IDLE
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = CAPTURE;
                    w_clr  = 1'b1;
                end
            end
            CAPTURE: begin
                w_accept = i_in_valid;
                if ((w_accept && w_last) || i_stop) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // registered RAM write: accept in cycle N strobes wr_en in cycle N+1
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_ptr;
                r_wr_data <= i_in_data;
            end
        end
    end

    assign o_in_ready = (r_state == CAPTURE);
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_fill     = w_fill;

`ifdef CAPTURE_OVERRUN_CNT_EN
    logic [OVR_W-1:0] r_overrun_cnt;

    // count samples offered outside a capture, saturating, cleared by reset only
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overrun_cnt <= '0;
        end else if (i_in_valid && !o_busy && (r_overrun_cnt != '1)) begin
            r_overrun_cnt <= r_overrun_cnt + OVR_W'(1);
        end
    end

    assign o_overrun_cnt = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_capture_writer.sv
// Bench for capture_writer: behavioural capture model feeding scoreboard
// queues of expected RAM writes and done events, a negedge monitor that
// consumes them, and per-cycle checks of the handshake/status outputs.
module tb_capture_writer;
    import capture_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_start = 1'b0;
    logic              i_stop = 1'b0;
    logic              i_in_valid = 1'b0;
    logic [DATA_W-1:0] i_in_data = '0;
    logic              o_in_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_fill;
`ifdef CAPTURE_OVERRUN_CNT_EN
    logic [OVR_W-1:0]  o_overrun_cnt;
`endif

    capture_writer #(.DEPTH(SAMPLE_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_in_valid (i_in_valid),
        .i_in_data  (i_in_data),
        .o_in_ready (o_in_ready),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_fill     (o_fill)
`ifdef CAPTURE_OVERRUN_CNT_EN
        ,
        .o_overrun_cnt (o_overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int fill;
        bit with_write;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];

    int checks = 0;
    int errors = 0;

    // model: phase 0 idle, 1 capturing, 2 done pulse
    int m_phase = 0;
    int m_fill  = 0;
    int m_ovr   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // monitor: every write strobe and done pulse must match the next expectation
    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d t=%0t", o_wr_addr, o_wr_data, $time);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", 32'(o_wr_addr), 32'(w.addr));
                chk("wr_data", 32'(o_wr_data), 32'(w.data));
            end
        end
        if (o_done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done fill=%0d t=%0t", o_fill, $time);
            end else begin
                done_t d;
                d = dq.pop_front();
                chk("done_fill", 32'(o_fill), 32'(d.fill));
                chk("done_with_write", 32'(o_wr_en), 32'(d.with_write));
            end
        end
    end

    // one clock: check status against model, drive inputs, advance model
    task automatic step(input bit s, input bit p, input bit v, input logic [DATA_W-1:0] d,
                        input bit rst = 1'b1);
        bit acc;
        @(negedge clk);
        chk("in_ready", 32'(o_in_ready), 32'(m_phase == 1));
        chk("busy", 32'(o_busy), 32'(m_phase != 0));
        chk("done_level", 32'(o_done), 32'(m_phase == 2));
        chk("fill", 32'(o_fill), 32'(m_fill));
`ifdef CAPTURE_OVERRUN_CNT_EN
        chk("overrun_cnt", 32'(o_overrun_cnt), 32'(m_ovr));
`endif
        reset      = rst;
        i_start    = s;
        i_stop     = p;
        i_in_valid = v;
        i_in_data  = d;
        @(posedge clk);
        if (!rst) begin
            m_phase = 0;
            m_fill  = 0;
            m_ovr   = 0;
        end else begin
            if (v && m_phase == 0 && m_ovr < 65535) m_ovr++;
            case (m_phase)
                0: if (s) begin
                    m_phase = 1;
                    m_fill  = 0;
                end
                1: begin
                    acc = v;
                    if (acc) begin
                        wq.push_back('{addr: ADDR_W'(m_fill), data: d});
                        m_fill++;
                    end
                    if (m_fill == SAMPLE_DEPTH || p) begin
                        m_phase = 2;
                        dq.push_back('{fill: m_fill, with_write: acc});
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_phase != 0; i++) step(0, 0, 0, '0);
    endtask

    initial begin
        // reset held with in_valid high
        for (int i = 0; i < 3; i++) step(0, 0, 1, DATA_W'($urandom), 1'b0);
        @(negedge clk);
        chk("rst_wr_en", 32'(o_wr_en), 0);
        chk("rst_wr_addr", 32'(o_wr_addr), 0);
        chk("rst_wr_data", 32'(o_wr_data), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_in_ready", 32'(o_in_ready), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_fill", 32'(o_fill), 0);
`ifdef CAPTURE_OVERRUN_CNT_EN
        chk("rst_overrun", 32'(o_overrun_cnt), 0);
`endif

        // samples offered while idle are dropped
        for (int i = 0; i < 5; i++) step(0, 0, 1, DATA_W'($urandom));
        step(0, 0, 0, '0);
`ifdef CAPTURE_OVERRUN_CNT_EN
        chk("overrun_5", 32'(o_overrun_cnt), 5);
`endif

        // full capture, data equals address
        step(1, 0, 0, '0);
        for (int i = 0; i < SAMPLE_DEPTH + 50 && m_phase != 0; i++)
            step(0, 0, 1, DATA_W'(m_fill));
        step(0, 0, 0, '0);
        chk("full_fill", 32'(o_fill), SAMPLE_DEPTH);

        // gapped valid pattern 1,0,0,1
        step(1, 0, 0, '0);
        for (int i = 0; i < 40; i++)
            step(0, 0, (i % 4 == 0) || (i % 4 == 3), DATA_W'($urandom));
        step(0, 1, 0, '0);
        drain();

        // early stop after 37 accepts with an accept in the stop cycle;
        // a start mid-capture is ignored
        step(1, 0, 0, '0);
        for (int i = 0; i < 100 && m_fill < 37; i++)
            step(i == 10, 0, 1, DATA_W'($urandom));
        step(0, 1, 1, DATA_W'($urandom));
        drain();
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("restart_fill_clear", 32'(o_fill), 0);
        chk("restart_busy", 32'(o_busy), 1);

        // random capture: random valid, random ignored starts, random stop point
        begin
            int stop_at;
            stop_at = 30 + int'($urandom_range(0, 60));
            for (int i = 0; i < stop_at; i++)
                step(($urandom % 8) == 0, 0, $urandom % 2, DATA_W'($urandom));
            step(0, 1, $urandom % 2, DATA_W'($urandom));
            drain();
        end

        // start and stop together in idle: start wins
        step(1, 1, 0, '0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, DATA_W'($urandom));
        step(0, 1, 0, '0);
        drain();

        // reset mid-capture at address 500
        step(1, 0, 0, '0);
        for (int i = 0; i < 600 && m_fill < 500; i++)
            step(0, 0, 1, DATA_W'($urandom));
        step(0, 0, 1, DATA_W'($urandom), 1'b0);
        step(0, 0, 1, DATA_W'($urandom), 1'b0);
        step(0, 0, 0, '0);
`ifdef CAPTURE_OVERRUN_CNT_EN
        chk("overrun_after_reset", 32'(o_overrun_cnt), 0);
`endif
        for (int i = 0; i < 10; i++) step(0, 0, 0, '0);
        chk("post_reset_fill", 32'(o_fill), 0);

        @(negedge clk);
        chk("writes_outstanding", 32'(wq.size()), 0);
        chk("dones_outstanding", 32'(dq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_writer.md
# capture_writer

Write-side counterpart of the playback address counter. It accepts a stream of samples over a valid/ready handshake and writes them into the shared sample RAM at addresses 0..DEPTH-1, in the same order the playback side later reads them. A capture is started by a `start` pulse and ends when the buffer is full or `stop` is pulsed. The block sits between the sample source (ADC/SPI front end) and the RAM write port.

## Interface
- `DEPTH`, 10000: number of sample slots; the address range is 0..DEPTH-1, matching the playback wrap point.
- `ADDR_W`, 16: width of the write address and the fill count.
- `DATA_W`, 16: sample width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a capture at address 0.
- `stop`  in  1  single-cycle pulse; ends the capture early.
- `in_valid`  in  1  source has a sample.
- `in_data`  in  DATA_W  sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  DATA_W  RAM write data.
- `busy`  out  1  capture in progress.
- `done`  out  1  single-cycle pulse at the end of a capture.
- `fill`  out  ADDR_W  number of samples written in the current or last capture.
- `overrun_cnt`  out  16  samples dropped; present only with CAPTURE_OVERRUN_CNT_EN.

## Operation
- States: IDLE, CAPTURE, DONE.
- **IDLE:** `in_ready`=0.
  - `start` moves to CAPTURE.
  - On that transition, `ptr` and `fill` clear to 0.
- **CAPTURE:** `in_ready`=1.
  - A sample is accepted when `in_valid` && `in_ready`.
  - On accept, the write is registered: next cycle `wr_en`=1, `wr_addr`=`ptr`, `wr_data`=`in_data`.
  - Also on accept, `ptr` and `fill` increment.
- **Last slot:** an accept at `ptr`==DEPTH-1 moves to DONE.
  - `in_ready` drops to 0 the cycle after that accept.
  - `ptr` never reaches DEPTH; there is no wrap inside one capture.
- **stop in CAPTURE:** moves to DONE.
  - An accept in the same cycle as `stop` is still written and counted.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **start while not in IDLE:** ignored.
- **start and stop in the same cycle in IDLE:** `start` wins and `stop` is ignored.
- **fill:** holds its value in IDLE until the next `start`.
- **Reset:** state IDLE. All outputs are 0: `in_ready`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `fill`, `overrun_cnt`.
- **Reset mid-capture:** the capture is abandoned. No `done` pulse and no further writes.

## Timing
- Latency: an accept in cycle N gives `wr_en` in cycle N+1. Write strobes are 1 cycle wide, one per accepted sample.
- `busy`=1 in CAPTURE and DONE. It rises the cycle after `start` and falls the cycle after `done`.
- **Final-slot timing:**
  - The final write (addr DEPTH-1) appears in the same cycle as `done`.
  - `fill`=DEPTH in that cycle.
  - `in_ready` is 0 in that cycle.
- Back-to-back: `start` in the cycle after `done` is accepted (IDLE reached).
- `in_data` is not sampled when `in_ready`=0.

## Configuration
- `CAPTURE_OVERRUN_CNT_EN` defined:
  - `overrun_cnt` counts cycles with `in_valid`=1 && `busy`=0, i.e. samples dropped outside a capture.
  - The count saturates at 16'hFFFF.
  - It clears only on reset.
- Undefined: the `overrun_cnt` port and its counter are absent.

## Structure
- Shared package `capture_pkg`:
  - state enum `capture_state_t` (IDLE, CAPTURE, DONE);
  - `SAMPLE_DEPTH`=10000, `ADDR_W`=16, `DATA_W`=16, shared with the playback counter so both ends agree on the wrap point.
- Natural sub-module: `capture_ptr`, the write pointer plus fill counter with clear/increment/terminal-count flag. FSM and handshake stay in the top.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `in_valid`=1 → all outputs 0, no `wr_en`.
- **Basic capture:** `start`, then continuous valid data = address → 10000 writes at addresses 0..9999 with `wr_data`=`wr_addr`. `done` coincides with addr 9999; `fill`=10000; `busy` falls the next cycle.
- **Gapped input:** `in_valid` toggling 1,0,0,1 → `wr_addr` advances only on accepts, with no skipped or duplicated address.
- **Early stop:** `stop` after 37 accepts, with an accept in the stop cycle → 38 writes (0..37), `done` one cycle after the stop, `fill`=38, then IDLE.
- **Restart:** `start` during CAPTURE is ignored. `start` the cycle after `done` restarts at address 0 with `fill` cleared.
- **With CAPTURE_OVERRUN_CNT_EN:** 5 valid cycles in IDLE → `overrun_cnt`=5. Reset mid-capture at addr 500 → no further writes, no `done`, `overrun_cnt`=0.
